// File: rtl/rx_pkt_word_buffer_pkg.sv
// Shared types and constants for the rx packet word buffer: write FSM states,
// length-FIFO entry sizing and drop-counter saturation.
package rx_pkt_word_buffer_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  // Length-FIFO entry: {fcs_ok, word_count}, word_count is addr_width+1 bits.
  function automatic int len_entry_width(input int addr_width);
    return 1 + addr_width + 1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_len_fifo.sv
// Synchronous show-ahead FIFO holding committed-frame descriptors.
// pop_data always presents the oldest entry while empty is low.
module rx_len_fifo #(
  parameter int WIDTH      = 11,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/rx_pkt_word_buffer.sv
// Packet-level elastic buffer: captures a frame's words tentatively, commits or
// rolls back on the FCS verdict, replays committed frames on AXI4-Stream.
// Optional macro RX_PASS_BAD_FCS_EN: commit bad-FCS frames with tuser=0.
module rx_pkt_word_buffer
  import rx_pkt_word_buffer_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 9,
  parameter int LEN_ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pkt_start_strobe,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_in_strobe,
  input  logic                  fcs_in_strobe,
  input  logic                  fcs_ok,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [15:0]           drop_count,
  output logic [ADDR_WIDTH:0]   words_used
);

  localparam int               PTR_W = ADDR_WIDTH + 1;
  localparam int               LEN_W = len_entry_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PTR_W-1:0] ONE   = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  wr_state_t        state, state_next;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] commit_ptr, commit_ptr_next;
  logic [PTR_W-1:0] word_cnt, word_cnt_next;
  logic [15:0]      drop_cnt, drop_cnt_next;
  logic [PTR_W-1:0] wr_ptr_adv, cnt_adv;
  logic             overflow;
  logic             mem_we;
  logic             full;
  logic             accept;

  logic             len_push, len_pop, len_full, len_empty;
  logic [LEN_W-1:0] len_push_data, len_pop_data;

  logic [PTR_W-1:0] rd_ptr, fetch_ptr, rd_remaining;
  logic             rd_active, rd_user;
  logic             issue, issue_last, handshake;

  assign full       = ((wr_ptr - rd_ptr) == DEPTH);
  assign drop_count = drop_cnt;

`ifdef RX_PASS_BAD_FCS_EN
  assign accept = 1'b1;
`else
  assign accept = fcs_ok;
`endif

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_next      = state;
    wr_ptr_next     = wr_ptr;
    commit_ptr_next = commit_ptr;
    word_cnt_next   = word_cnt;
    drop_cnt_next   = drop_cnt;
    wr_ptr_adv      = wr_ptr;
    cnt_adv         = word_cnt;
    overflow        = 1'b0;
    mem_we          = 1'b0;
    len_push        = 1'b0;
    len_push_data   = {fcs_ok, word_cnt};

    if (pkt_start_strobe) begin
      wr_ptr_next   = commit_ptr;
      word_cnt_next = '0;
      state_next    = W_RECV;
    end else begin
      case (state)
        W_RECV: begin
          if (word_in_strobe) begin
            if (full) begin
              overflow = 1'b1;
            end else begin
              mem_we     = 1'b1;
              wr_ptr_adv = wr_ptr + ONE;
              cnt_adv    = word_cnt + ONE;
            end
          end
          // A word arriving with the verdict belongs to the committed frame.
          len_push_data = {fcs_ok, cnt_adv};

          if (overflow) begin
            wr_ptr_next = commit_ptr;
            if (fcs_in_strobe) begin
              drop_cnt_next = sat_inc16(drop_cnt);
              state_next    = W_IDLE;
            end else begin
              state_next = W_DROP;
            end
          end else if (fcs_in_strobe) begin
            state_next = W_IDLE;
            if (cnt_adv == '0) begin
              wr_ptr_next = wr_ptr_adv;
            end else if (accept && !len_full) begin
              commit_ptr_next = wr_ptr_adv;
              wr_ptr_next     = wr_ptr_adv;
              len_push        = 1'b1;
            end else begin
              wr_ptr_next   = commit_ptr;
              drop_cnt_next = sat_inc16(drop_cnt);
            end
          end else begin
            wr_ptr_next   = wr_ptr_adv;
            word_cnt_next = cnt_adv;
          end
        end

        W_DROP: begin
          if (fcs_in_strobe) begin
            drop_cnt_next = sat_inc16(drop_cnt);
            state_next    = W_IDLE;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rstn) begin
      state      <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      word_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_ptr_next;
      commit_ptr <= commit_ptr_next;
      word_cnt   <= word_cnt_next;
      drop_cnt   <= drop_cnt_next;
    end
  end

  // NOTE: word storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= word_in;
    end
  end

  rx_len_fifo #(
    .WIDTH      (LEN_W),
    .ADDR_WIDTH (LEN_ADDR_WIDTH)
  ) u_len_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (len_push),
    .push_data (len_push_data),
    .pop       (len_pop),
    .pop_data  (len_pop_data),
    .full      (len_full),
    .empty     (len_empty)
  );

  // ---------------------------------------------------------------------------
  // Read side: descriptor stage feeds a single registered output stage.
  // fetch_ptr runs ahead of rd_ptr by at most the word held in the output.
  // ---------------------------------------------------------------------------
  assign handshake  = m_axis_tvalid && m_axis_tready;
  assign issue      = rd_active && (!m_axis_tvalid || m_axis_tready);
  assign issue_last = issue && (rd_remaining == ONE);
  // Popping alongside the last issue keeps back-to-back frames bubble-free.
  assign len_pop    = !len_empty && (!rd_active || issue_last);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_active     <= 1'b0;
      rd_remaining  <= '0;
      rd_user       <= 1'b0;
      fetch_ptr     <= '0;
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      words_used    <= '0;
    end else begin
      if (len_pop) begin
        rd_active    <= 1'b1;
        rd_remaining <= len_pop_data[PTR_W-1:0];
        rd_user      <= len_pop_data[LEN_W-1];
      end else if (issue) begin
        rd_active    <= !issue_last;
        rd_remaining <= rd_remaining - ONE;
      end

      if (issue)     fetch_ptr <= fetch_ptr + ONE;
      if (handshake) rd_ptr    <= rd_ptr + ONE;

      if (issue) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (rd_remaining == ONE);
        m_axis_tuser  <= rd_user;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      words_used <= wr_ptr - rd_ptr;
    end
  end

  // Data is qualified by tvalid, so it needs no reset and maps onto a RAM read port.
  always_ff @(posedge clk) begin
    if (issue) begin
      m_axis_tdata <= mem[fetch_ptr[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_rx_pkt_word_buffer.sv
// Directed bench for rx_pkt_word_buffer (16-word memory so overflow is reachable).
module tb_rx_pkt_word_buffer;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int LAW = 4;
`ifdef RX_PASS_BAD_FCS_EN
  localparam bit PASS_BAD = 1'b1;
`else
  localparam bit PASS_BAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pkt_start_strobe = 1'b0;
  logic [DW-1:0] word_in = '0;
  logic          word_in_strobe = 1'b0;
  logic          fcs_in_strobe = 1'b0;
  logic          fcs_ok = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [15:0]   drop_count;
  logic [AW:0]   words_used;

  rx_pkt_word_buffer #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .LEN_ADDR_WIDTH (LAW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .pkt_start_strobe (pkt_start_strobe),
    .word_in          (word_in),
    .word_in_strobe   (word_in_strobe),
    .fcs_in_strobe    (fcs_in_strobe),
    .fcs_ok           (fcs_ok),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .drop_count       (drop_count),
    .words_used       (words_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  beat_t beats[$];

  always @(negedge clk) begin
    if (rstn && m_axis_tvalid && m_axis_tready)
      beats.push_back('{data: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser});
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_drops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    pkt_start_strobe = 1'b1;
    tick();
    pkt_start_strobe = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    word_in        = w;
    word_in_strobe = 1'b1;
    tick();
    word_in_strobe = 1'b0;
  endtask

  task automatic send_fcs(input logic ok);
    fcs_ok        = ok;
    fcs_in_strobe = 1'b1;
    tick();
    fcs_in_strobe = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) send_word(base + DW'(i));
  endtask

  task automatic send_frame(input int n, input logic [DW-1:0] base, input logic ok);
    start_pkt();
    send_words(n, base);
    send_fcs(ok);
  endtask

  // Consumes n beats from the monitor queue and checks an ascending frame.
  task automatic check_frame(input string tag, input logic [DW-1:0] base,
                             input int n, input logic user);
    int avail;
    beat_t b;
    avail = (beats.size() < n) ? beats.size() : n;
    check({tag, ".beats_avail"}, 64'(avail), 64'(n));
    for (int i = 0; i < avail; i++) begin
      b = beats.pop_front();
      check($sformatf("%s.data[%0d]", tag, i), b.data, base + DW'(i));
      check($sformatf("%s.last[%0d]", tag, i), 64'(b.last), 64'(i == n - 1));
      check($sformatf("%s.user[%0d]", tag, i), 64'(b.user), 64'(user));
    end
  endtask

  typedef struct {
    int            n;
    logic [DW-1:0] base;
    logic          ok;
    int            exp_beats;
    int            exp_drop_inc;
    logic          exp_user;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int run;
    logic [3:0] pat;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_user;

    vecs[0] = '{n: 1,  base: 64'h100, ok: 1'b1, exp_beats: 1,  exp_drop_inc: 0, exp_user: 1'b1};
    vecs[1] = '{n: 0,  base: 64'h0,   ok: 1'b1, exp_beats: 0,  exp_drop_inc: 0, exp_user: 1'b1};
    vecs[2] = '{n: 5,  base: 64'h300, ok: 1'b0, exp_beats: PASS_BAD ? 5 : 0,
                exp_drop_inc: PASS_BAD ? 0 : 1, exp_user: 1'b0};
    vecs[3] = '{n: 16, base: 64'h400, ok: 1'b1, exp_beats: 16, exp_drop_inc: 0, exp_user: 1'b1};
    vecs[4] = '{n: 7,  base: 64'h500, ok: 1'b0, exp_beats: PASS_BAD ? 7 : 0,
                exp_drop_inc: PASS_BAD ? 0 : 1, exp_user: 1'b0};
    vecs[5] = '{n: 2,  base: 64'h600, ok: 1'b1, exp_beats: 2,  exp_drop_inc: 0, exp_user: 1'b1};

    // Reset state
    rstn = 1'b0;
    repeat (2) tick();
    check("rst.tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst.tlast", 64'(m_axis_tlast), 64'd0);
    check("rst.tuser", 64'(m_axis_tuser), 64'd0);
    check("rst.drop", 64'(drop_count), 64'd0);
    check("rst.used", 64'(words_used), 64'd0);
    rstn = 1'b1;
    tick();

    // Good 13-word frame with latency measurement
    m_axis_tready = 1'b1;
    start_pkt();
    send_words(13, 64'h1);
    fcs_ok        = 1'b1;
    fcs_in_strobe = 1'b1;
    tick();
    fcs_in_strobe = 1'b0;
    lat = 1;
    while (!m_axis_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("good.latency", 64'(lat), 64'd3);
    repeat (20) tick();
    check_frame("good", 64'h1, 13, 1'b1);
    check("good.drop", 64'(drop_count), 64'd0);
    check("good.used", 64'(words_used), 64'd0);

    // Table of single frames with continuous ready
    foreach (vecs[k]) begin
      beats.delete();
      send_frame(vecs[k].n, vecs[k].base, vecs[k].ok);
      repeat (30) tick();
      exp_drops += vecs[k].exp_drop_inc;
      check_frame($sformatf("vec%0d", k), vecs[k].base, vecs[k].exp_beats, vecs[k].exp_user);
      check($sformatf("vec%0d.extra", k), 64'(beats.size()), 64'd0);
      check($sformatf("vec%0d.drop", k), 64'(drop_count), 64'(exp_drops));
      check($sformatf("vec%0d.used", k), 64'(words_used), 64'd0);
    end

    // Exactly-full frame while stalled
    beats.delete();
    m_axis_tready = 1'b0;
    send_frame(16, 64'h900, 1'b1);
    repeat (3) tick();
    check("exact.used", 64'(words_used), 64'd16);
    check("exact.drop", 64'(drop_count), 64'(exp_drops));
    m_axis_tready = 1'b1;
    repeat (25) tick();
    check_frame("exact", 64'h900, 16, 1'b1);

    // Overflow: second frame does not fit behind the first
    beats.delete();
    m_axis_tready = 1'b0;
    send_frame(10, 64'hA00, 1'b1);
    send_frame(10, 64'hB00, 1'b1);
    exp_drops++;
    repeat (3) tick();
    check("ovf.drop", 64'(drop_count), 64'(exp_drops));
    check("ovf.used", 64'(words_used), 64'd10);
    check("ovf.stall_valid", 64'(m_axis_tvalid), 64'd1);
    check("ovf.stall_data", m_axis_tdata, 64'hA00);
    m_axis_tready = 1'b1;
    repeat (20) tick();
    check_frame("ovf", 64'hA00, 10, 1'b1);
    check("ovf.extra", 64'(beats.size()), 64'd0);

    // Abort: restarted frame replaces the unfinished one silently
    beats.delete();
    start_pkt();
    send_words(4, 64'hC00);
    start_pkt();
    send_words(2, 64'hD00);
    send_fcs(1'b1);
    repeat (15) tick();
    check_frame("abort", 64'hD00, 2, 1'b1);
    check("abort.extra", 64'(beats.size()), 64'd0);
    check("abort.drop", 64'(drop_count), 64'(exp_drops));

    // Backpressure: ready pattern 1,0,0,1 over two 3-word frames
    beats.delete();
    m_axis_tready = 1'b0;
    send_frame(3, 64'hE00, 1'b1);
    send_frame(3, 64'hE10, 1'b1);
    repeat (3) tick();
    pat = 4'b1001;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    prev_user  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (prev_stall) begin
        check($sformatf("bp.hold_valid[%0d]", i), 64'(m_axis_tvalid), 64'd1);
        check($sformatf("bp.hold_data[%0d]", i), m_axis_tdata, prev_data);
        check($sformatf("bp.hold_last[%0d]", i), 64'(m_axis_tlast), 64'(prev_last));
        check($sformatf("bp.hold_user[%0d]", i), 64'(m_axis_tuser), 64'(prev_user));
      end
      m_axis_tready = pat[i % 4];
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      prev_user  = m_axis_tuser;
      tick();
    end
    m_axis_tready = 1'b1;
    repeat (10) tick();
    check("bp.total", 64'(beats.size()), 64'd6);
    check_frame("bp.f1", 64'hE00, 3, 1'b1);
    check_frame("bp.f2", 64'hE10, 3, 1'b1);

    // Back-to-back frames drain without a bubble
    beats.delete();
    m_axis_tready = 1'b0;
    send_frame(3, 64'hF00, 1'b1);
    send_frame(3, 64'hF10, 1'b1);
    repeat (4) tick();
    m_axis_tready = 1'b1;
    run = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_axis_tvalid) run++;
      tick();
    end
    check("b2b.valid_cycles", 64'(run), 64'd6);
    repeat (5) tick();
    check_frame("b2b.f1", 64'hF00, 3, 1'b1);
    check_frame("b2b.f2", 64'hF10, 3, 1'b1);

    // Reset during readout and mid-frame
    beats.delete();
    m_axis_tready = 1'b0;
    send_frame(5, 64'h1100, 1'b1);
    start_pkt();
    send_words(2, 64'h1200);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_drops = 0;
    check("rst2.tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst2.used", 64'(words_used), 64'd0);
    check("rst2.drop", 64'(drop_count), 64'd0);
    tick();
    check("rst2.used_after", 64'(words_used), 64'd0);
    m_axis_tready = 1'b1;
    send_words(2, 64'h1300);
    send_frame(3, 64'h1400, 1'b1);
    repeat (15) tick();
    check_frame("rst2.frame", 64'h1400, 3, 1'b1);
    check("rst2.extra", 64'(beats.size()), 64'd0);
    check("rst2.drop_final", 64'(drop_count), 64'(exp_drops));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
